// File: rtl/text_scanout.sv
// text_scanout
//   Video-side reader of the character VRAM. Generates VGA timing from the
//   pixel clock, walks the 80x30 grid of 8x16 text cells, drives the VRAM
//   read address and hands the fetched character code plus glyph position and
//   syncs, all aligned to one cycle of latency, to the font/pixel stage.
//   Output stream: one pixel per clock, no back-pressure; de marks the
//   visible pixels and char_code is forced to 0 whenever de is 0.
//
// Ports
//   clk               pixel clock, sole clock
//   rst               asynchronous reset, active low
//   row_offset        vertical scroll in text rows, taken once per frame
//   vram_read_address {row[4:0], col[6:0]}, combinational from the counters
//   vram_read_data    VRAM data, registered by the VRAM on the falling edge
//   char_code         character under the current pixel (0 outside de)
//   glyph_row         pixel row inside the cell
//   glyph_col         pixel column inside the cell
//   de                display enable
//   hsync, vsync      active-low syncs
//   frame_start       one-cycle pulse with the first visible pixel
module text_scanout #(
  parameter int READ_ADDR_SIZE = 12,
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                row_offset,
  output logic [READ_ADDR_SIZE-1:0] vram_read_address,
  input  logic [7:0]                vram_read_data,
  output logic [7:0]                char_code,
  output logic [3:0]                glyph_row,
  output logic [2:0]                glyph_col,
  output logic                      de,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [5:0] TEXT_ROWS  = 6'd30;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [4:0]  off_q;
  logic        h_last;
  logic        v_last;

  // Stage 0 signals
  logic        vis0;
  logic        hsync0;
  logic        vsync0;
  logic [6:0]  col;
  logic [4:0]  cell_row;
  logic [5:0]  row_sum;
  logic [4:0]  row;
  logic [11:0] addr_full;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (h_last) begin
      h_cnt <= 10'd0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Scroll offset is captured only on the last pixel of a frame so the whole
  // frame is drawn with one offset. Out-of-range offsets fall back to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_q <= 5'd0;
    end else if (h_last && v_last) begin
      off_q <= (row_offset >= 5'd30) ? 5'd0 : row_offset;
    end
  end

  always_comb begin
    vis0     = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hsync0   = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vsync0   = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    col      = h_cnt[9:3];
    cell_row = v_cnt[8:4];
    // Both operands are below 30, so one conditional subtract is a full
    // modulo-30 reduction; 6 bits hold the sum without overflow.
    row_sum  = {1'b0, cell_row} + {1'b0, off_q};
    row      = (row_sum >= TEXT_ROWS) ? 5'(row_sum - TEXT_ROWS) : row_sum[4:0];
    addr_full = {row, col};
  end

  assign vram_read_address = vis0 ? addr_full[READ_ADDR_SIZE-1:0] : '0;

  // Stage 1: VRAM data arrives on the falling edge of the same cycle the
  // address is presented, so everything lines up with a single register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_code   <= 8'd0;
      glyph_row   <= 4'd0;
      glyph_col   <= 3'd0;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      char_code   <= vis0 ? vram_read_data : 8'd0;
      glyph_row   <= v_cnt[3:0];
      glyph_col   <= h_cnt[2:0];
      de          <= vis0;
      hsync       <= hsync0;
      vsync       <= vsync0;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

endmodule

// File: tb/tb_text_scanout.sv
// tb_text_scanout
//   Two instances share clock, reset and row_offset: dut_b uses the standard
//   640x480 timing, dut_s a shrunken raster so that frame boundaries, vsync
//   and scroll reloads occur within a short run. A raster model computes
//   every expected output from the pixel index since reset release.
module tb_text_scanout;

  // Small raster: 192 x 56 lines
  localparam int SHV = 160, SHF = 8, SHS = 16, SHB = 8;
  localparam int SVV = 48, SVF = 3, SVS = 2, SVB = 3;
  localparam int HT_S = SHV + SHF + SHS + SHB;
  localparam int FT_S = HT_S * (SVV + SVF + SVS + SVB);
  // Standard raster
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVV = 480, BVF = 10, BVS = 2, BVB = 33;
  localparam int FT_B = 800 * 525;

  logic        clk;
  logic        rst;
  logic [4:0]  row_offset;
  logic [11:0] addr_s, addr_b;
  logic [7:0]  rdata_s, rdata_b, char_s, char_b;
  logic [3:0]  grow_s, grow_b;
  logic [2:0]  gcol_s, gcol_b;
  logic        de_s, de_b, hs_s, hs_b, vs_s, vs_b, fs_s, fs_b;

  logic [7:0]  mem [0:4095];

  logic [11:0] addr_q_s[$], addr_q_b[$];
  logic [18:0] exp_q_s[$], exp_q_b[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  int p;
  int off_s [0:7];
  int off_b [0:1];

  text_scanout #(
    .READ_ADDR_SIZE(12),
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .clk(clk), .rst(rst), .row_offset(row_offset),
    .vram_read_address(addr_s), .vram_read_data(rdata_s),
    .char_code(char_s), .glyph_row(grow_s), .glyph_col(gcol_s),
    .de(de_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  text_scanout dut_b (
    .clk(clk), .rst(rst), .row_offset(row_offset),
    .vram_read_address(addr_b), .vram_read_data(rdata_b),
    .char_code(char_b), .glyph_row(grow_b), .glyph_col(gcol_b),
    .de(de_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  // ---------------- clock / VRAM models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    rdata_s <= mem[addr_s];
    rdata_b <= mem[addr_b];
  end

  // ---------------- reference model ----------------
  // Returns {address[11:0], char[7:0], glyph_row[3:0], glyph_col[2:0], de, hsync, vsync, frame_start}
  // for raster position pos (pixel index since release).
  function automatic logic [30:0] model(input int pos, input int off,
                                        input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb);
    int ht, vt, h, v, row;
    logic vis;
    logic [11:0] a;
    logic [7:0] c;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    h   = pos % ht;
    v   = (pos / ht) % vt;
    vis = (h < hv) && (v < vv);
    row = ((v / 16) + off) % 30;
    a   = vis ? 12'(row * 128 + h / 8) : 12'd0;
    c   = vis ? mem[a] : 8'd0;
    return {a, c, 4'(v % 16), 3'(h % 8), vis,
            !((h >= hv + hf) && (h < hv + hf + hsw)),
            !((v >= vv + vf) && (v < vv + vf + vsw)),
            (h == 0) && (v == 0)};
  endfunction

  function automatic logic [30:0] model_s(input int pos);
    return model(pos, off_s[pos / FT_S], SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic logic [30:0] model_b(input int pos);
    return model(pos, off_b[pos / FT_B], BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
  endfunction

  function automatic int sat(input logic [4:0] x);
    return (x >= 5'd30) ? 0 : int'(x);
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (p=%0d)", name, got, exp, p);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr_s"}, 32'(addr_s), 32'h0);
    check({tag, "_addr_b"}, 32'(addr_b), 32'h0);
    check({tag, "_out_s"}, 32'({char_s, grow_s, gcol_s, de_s, hs_s, vs_s, fs_s}), 32'h6);
    check({tag, "_out_b"}, 32'({char_b, grow_b, gcol_b, de_b, hs_b, vs_b, fs_b}), 32'h6);
  endtask

  // ---------------- monitors ----------------
  initial forever begin : mon_small
    logic [11:0] ea;
    logic [18:0] eo;
    @(negedge clk);
    #2;
    if (mon_en) begin
      total++;
      if (addr_q_s.size() == 0 || exp_q_s.size() == 0) begin
        bad++;
        $display("FAIL small_queue empty");
      end else begin
        ea = addr_q_s.pop_front();
        eo = exp_q_s.pop_front();
        if (addr_s !== ea) begin
          bad++;
          $display("FAIL small_addr got=%03h exp=%03h", addr_s, ea);
        end
        total++;
        if ({char_s, grow_s, gcol_s, de_s, hs_s, vs_s, fs_s} !== eo) begin
          bad++;
          $display("FAIL small_out got char=%02h row=%0d col=%0d de/hs/vs/fs=%b%b%b%b exp char=%02h row=%0d col=%0d de/hs/vs/fs=%b",
                   char_s, grow_s, gcol_s, de_s, hs_s, vs_s, fs_s, eo[18:11], eo[10:7], eo[6:4], eo[3:0]);
        end
      end
    end
  end

  initial forever begin : mon_big
    logic [11:0] ea;
    logic [18:0] eo;
    @(negedge clk);
    #2;
    if (mon_en) begin
      total++;
      if (addr_q_b.size() == 0 || exp_q_b.size() == 0) begin
        bad++;
        $display("FAIL big_queue empty");
      end else begin
        ea = addr_q_b.pop_front();
        eo = exp_q_b.pop_front();
        if (addr_b !== ea) begin
          bad++;
          $display("FAIL big_addr got=%03h exp=%03h", addr_b, ea);
        end
        total++;
        if ({char_b, grow_b, gcol_b, de_b, hs_b, vs_b, fs_b} !== eo) begin
          bad++;
          $display("FAIL big_out got char=%02h row=%0d col=%0d de/hs/vs/fs=%b%b%b%b exp char=%02h row=%0d col=%0d de/hs/vs/fs=%b",
                   char_b, grow_b, gcol_b, de_b, hs_b, vs_b, fs_b, eo[18:11], eo[10:7], eo[6:4], eo[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run();
    logic [30:0] m;
    p = 0;
    foreach (off_s[i]) off_s[i] = 0;
    foreach (off_b[i]) off_b[i] = 0;
    addr_q_s.delete();
    addr_q_b.delete();
    exp_q_s.delete();
    exp_q_b.delete();
    m = model_s(0);
    exp_q_s.push_back(m[18:0]);
    m = model_b(0);
    exp_q_b.push_back(m[18:0]);
    rst = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    p++;
  endtask

  // Record the offset the next rising edge will capture at a frame end, then
  // queue the expectations for the current raster position.
  task automatic push_expect();
    logic [30:0] m;
    if ((p + 1) % FT_S == 0 && (p + 1) / FT_S < 8) off_s[(p + 1) / FT_S] = sat(row_offset);
    if ((p + 1) % FT_B == 0 && (p + 1) / FT_B < 2) off_b[(p + 1) / FT_B] = sat(row_offset);
    m = model_s(p);
    addr_q_s.push_back(m[30:19]);
    exp_q_s.push_back(m[18:0]);
    m = model_b(p);
    addr_q_b.push_back(m[30:19]);
    exp_q_b.push_back(m[18:0]);
    mon_en = 1'b1;
  endtask

  task automatic check_first();
    check("first_s", 32'({de_s, fs_s, grow_s, gcol_s}), 32'({1'b1, 1'b1, 4'h0, 3'h0}));
    check("first_b", 32'({de_b, fs_b, grow_b, gcol_b}), 32'({1'b1, 1'b1, 4'h0, 3'h0}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int de_cnt, hs_cnt, vs_cnt;
    de_cnt = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    rst = 1'b0;
    row_offset = 5'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i + 1);

    repeat (3) @(negedge clk);
    #1;
    check_reset("reset_hold");
    start_run();

    // Phase A: fixed VRAM pattern, scripted scroll changes
    for (int k = 0; k < 28100; k++) begin
      step();
      if (p == 1000) row_offset = 5'd29;
      if (p == FT_S + 30 * HT_S) row_offset = 5'd5;
      push_expect();
      if (p == 1) check_first();
      if (p >= 1 && p <= 800) begin
        if (de_b) de_cnt++;
        if (!hs_b) hs_cnt++;
      end
      if (p == 800) begin
        check("de_per_line", 32'(de_cnt), 32'd640);
        check("hsync_width", 32'(hs_cnt), 32'd96);
      end
      if (p == 656) check("hsync_before", 32'(hs_b), 32'd1);
      if (p == 657) check("hsync_fall", 32'(hs_b), 32'd0);
      if (p == 752) check("hsync_last", 32'(hs_b), 32'd0);
      if (p == 753) check("hsync_rise", 32'(hs_b), 32'd1);
      if (p == 35 * 800 + 17) check("fetch_addr", 32'(addr_b), 32'h102);
      if (p == 35 * 800 + 18)
        check("fetch_out", 32'({char_b, gcol_b, grow_b}), 32'({8'h03, 3'd1, 4'd3}));
      if (p >= 1 && p <= FT_S && !vs_s) vs_cnt++;
      if (p == FT_S) begin
        check("vsync_width", 32'(vs_cnt), 32'(2 * HT_S));
        check("fs_not_early", 32'(fs_s), 32'd0);
        check("wrap_v0", 32'(addr_s), 32'hE80);
      end
      if (p == FT_S + 1) check("fs_period", 32'(fs_s), 32'd1);
      if (p == FT_S + 16 * HT_S) check("wrap_v16", 32'(addr_s), 32'h000);
      if (p == FT_S + 40 * HT_S) check("offset_held", 32'(addr_s), 32'h080);
      if (p == 2 * FT_S) check("offset_next", 32'(addr_s), 32'h280);
      if (p == 2 * FT_S + 16 * HT_S + 17) check("offset_next_v16", 32'(addr_s), 32'h302);
    end

    // Reset mid-frame: outputs must clear at once
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check_reset("reset_mid");
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    #1;
    start_run();

    // Phase C: random VRAM, out-of-range offset, then random offset changes
    for (int k = 0; k < 27000; k++) begin
      step();
      if (p == 5) row_offset = 5'd31;
      else if (p >= FT_S && $urandom_range(0, 1999) == 0) row_offset = 5'($urandom_range(0, 31));
      push_expect();
      if (p == 1) check_first();
      if (p == FT_S + 16 * HT_S) check("offset_31_as_0", 32'(addr_s), 32'h080);
    end
    #2;
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
